sram_read_slave: RTL and testbench
==================================

# sram_read_slave

AXI read-side slave responder that sits between one crossbar slave port and a single-port synchronous SRAM. It accepts read-address requests, fetches each beat from the SRAM, and returns it as a registered R-channel burst. It drives the RID/RDATA/RRESP/RLAST/RVALID inputs that the crossbar's read-data router consumes, and it honours that router's RREADY backpressure.

## Interface
- IDS_W, 8: slave-side ID width; [7:4] is the master tag, [3:0] is the transaction ID, passed through untouched.
- DATA_W, 32: data width; one beat is one word.
- ADDR_W, 32: AXI address width.
- MEM_AW, 14: SRAM word-address width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ARID  in  IDS_W  request ID.
- ARADDR  in  ADDR_W  byte address of the first beat.
- ARLEN  in  4  beats minus 1.
- ARSIZE  in  3  beat size; only 3'b010 is supported.
- ARBURST  in  2  burst type: 2'b00 FIXED, 2'b01 INCR; any other value is unsupported.
- ARVALID  in  1  address valid.
- ARREADY  out  1  address ready.
- RID  out  IDS_W  response ID.
- RDATA  out  DATA_W  read data.
- RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- RLAST  out  1  final beat.
- RVALID  out  1  data valid.
- RREADY  in  1  data ready from the crossbar.
- mem_cs  out  1  SRAM chip select (read strobe).
- mem_addr  out  MEM_AW  SRAM word address.
- mem_rdata  in  DATA_W  SRAM output; valid in the cycle after the edge that sampled mem_cs=1.

## Operation
- FSM states: IDLE, FETCH, WAIT, RESP.
- IDLE:
  - ARREADY=1.
  - On ARVALID&ARREADY, latch the following, then go to FETCH:
    - ARID into id_r.
    - ARLEN into len_r.
    - ARADDR[MEM_AW+1:2] into addr_r.
    - err_r = (ARSIZE!=3'b010) | (ARBURST[1]==1).
    - beat_r = 0.
- FETCH:
  - mem_cs = ~err_r; mem_addr = addr_r.
  - Next state is WAIT.
- WAIT:
  - At the clock edge, capture mem_rdata into RDATA, or 0 if err_r.
  - Set RVALID=1, RLAST=(beat_r==len_r), RRESP = err_r ? 2'b10 : 2'b00, RID=id_r.
  - Next state is RESP.
- RESP:
  - Hold RID, RDATA, RRESP and RLAST stable while RVALID & ~RREADY.
  - On RREADY with RLAST=1: clear RVALID and RLAST, go to IDLE.
  - On RREADY with RLAST=0: clear RVALID, beat_r += 1, and go to FETCH.
    - INCR: addr_r += 1, wrapping modulo 2^MEM_AW.
    - FIXED: addr_r unchanged.
- Error bursts still return exactly len_r+1 beats, every beat SLVERR, and the SRAM is never selected.
- mem_cs=0 in every state except FETCH. mem_addr=addr_r at all times.
- Only one outstanding transaction. No AR is accepted before the last R handshake of the current burst.

## Timing
- ARREADY is registered:
  - 0 in reset.
  - Rises on the first edge after rst deasserts.
  - Falls on the edge that completes the AR handshake.
  - Rises on the edge that completes the final R handshake.
- Reset values: ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=2'b00, mem_cs=0, mem_addr=0, state=IDLE.
- Latency: AR handshake at edge E gives mem_cs=1 during cycle E..E+1 and RVALID=1 from edge E+2.
- Beat rate: best case 3 cycles per beat with RREADY held high. The next beat's RVALID comes 2 edges after the R handshake edge.
- RVALID never depends combinationally on RREADY. RVALID, once set, stays high until the handshake.
- ARLEN=15 gives 16 beats; beat_r is 4 bits and never overflows.
- INCR from the top word address 2^MEM_AW-1 wraps to 0.
- Reset asserted mid-burst forces the reset values immediately (asynchronously) and abandons the burst. After release, the block accepts a fresh AR with no residual beats.

## Test plan
- Single beat: ARID=8'h13, ARADDR=32'h40, ARLEN=0, INCR, SRAM word 0x10 = 32'hDEADBEEF, RREADY=1 -> mem_addr=0x10 strobed once; one beat with RID=8'h13, RDATA=32'hDEADBEEF, RLAST=1, RRESP=00; ARREADY back to 1 the edge after the handshake.
- INCR burst: ARADDR=32'h100, ARLEN=3, SRAM words 0x40..0x43 = 1,2,3,4 -> four beats carrying 1,2,3,4, RLAST only on the 4th, 3 cycles between beats.
- Backpressure: same as the previous scenario but RREADY low for 5 cycles on beat 2 -> RDATA=2, RLAST=0 and RID held stable; no extra mem_cs pulse; burst completes with 4 beats.
- FIXED burst and wrap:
  - ARBURST=00, ARLEN=2 -> three identical beats from one address.
  - INCR, ARLEN=1, start at word 2^14-1 -> second beat reads word 0.
- Error: ARSIZE=3'b001, ARLEN=1 -> two beats, RRESP=2'b10, RDATA=0, mem_cs never asserted.
- Reset mid-burst: assert rst during beat 2 of ARLEN=3 -> all outputs 0 immediately; after release ARREADY=1 one edge later; a new single-beat read returns correct data.

Source files
------------

// File: rtl/sram_read_slave.sv
// AXI read responder for a single-port synchronous SRAM: one burst at a time,
// one SRAM fetch per beat, registered R channel with RREADY backpressure.
//
// state | meaning
// IDLE  | ARREADY high, waiting for an AR request
// FETCH | SRAM strobed at r_addr (suppressed for error bursts)
// WAIT  | SRAM data returns, captured into the R registers
// RESP  | RVALID high, holding the beat until RREADY
module sram_read_slave #(
    parameter int IDS_W  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDS_W-1:0]  ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [IDS_W-1:0]  RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              mem_cs,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [IDS_W-1:0]    r_id,      w_id_nxt;
    logic [3:0]          r_len,     w_len_nxt;
    logic [3:0]          r_beat,    w_beat_nxt;
    logic [MEM_AW-1:0]   r_addr,    w_addr_nxt;
    logic                r_err,     w_err_nxt;
    logic                r_incr,    w_incr_nxt;
    logic                r_arready, w_arready_nxt;
    logic                r_rvalid,  w_rvalid_nxt;
    logic                r_rlast,   w_rlast_nxt;
    logic [IDS_W-1:0]    r_rid,     w_rid_nxt;
    logic [DATA_W-1:0]   r_rdata,   w_rdata_nxt;
    logic [1:0]          r_rresp,   w_rresp_nxt;
    logic                w_ar_hs;
    logic                w_unused;

    // Byte-lane and above-SRAM address bits carry no information for word reads.
    assign w_unused = ^{ARADDR[ADDR_W-1:MEM_AW+2], ARADDR[1:0]};

    assign w_ar_hs = (r_state == S_IDLE) & r_arready & ARVALID;

    always_comb begin
        w_state_nxt   = r_state;
        w_id_nxt      = r_id;
        w_len_nxt     = r_len;
        w_beat_nxt    = r_beat;
        w_addr_nxt    = r_addr;
        w_err_nxt     = r_err;
        w_incr_nxt    = r_incr;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rlast_nxt   = r_rlast;
        w_rid_nxt     = r_rid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;

        case (r_state)
            S_IDLE: begin
                w_arready_nxt = 1'b1;
                if (w_ar_hs) begin
                    w_id_nxt      = ARID;
                    w_len_nxt     = ARLEN;
                    w_addr_nxt    = ARADDR[MEM_AW+1:2];
                    w_err_nxt     = (ARSIZE != 3'b010) | ARBURST[1];
                    w_incr_nxt    = (ARBURST == 2'b01);
                    w_beat_nxt    = 4'd0;
                    w_arready_nxt = 1'b0;
                    w_state_nxt   = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_rdata_nxt  = r_err ? '0 : mem_rdata;
                w_rvalid_nxt = 1'b1;
                w_rlast_nxt  = (r_beat == r_len);
                w_rresp_nxt  = r_err ? 2'b10 : 2'b00;
                w_rid_nxt    = r_id;
                w_state_nxt  = S_RESP;
            end
            S_RESP: begin
                if (RREADY) begin
                    w_rvalid_nxt = 1'b0;
                    if (r_rlast) begin
                        w_rlast_nxt   = 1'b0;
                        w_arready_nxt = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_beat_nxt  = r_beat + 4'd1;
                        // Natural MEM_AW-bit wrap at the top of the SRAM.
                        if (r_incr)
                            w_addr_nxt = r_addr + {{(MEM_AW-1){1'b0}}, 1'b1};
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_id      <= '0;
            r_len     <= 4'd0;
            r_beat    <= 4'd0;
            r_addr    <= '0;
            r_err     <= 1'b0;
            r_incr    <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            r_state   <= w_state_nxt;
            r_id      <= w_id_nxt;
            r_len     <= w_len_nxt;
            r_beat    <= w_beat_nxt;
            r_addr    <= w_addr_nxt;
            r_err     <= w_err_nxt;
            r_incr    <= w_incr_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rlast   <= w_rlast_nxt;
            r_rid     <= w_rid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
        end
    end

    assign ARREADY  = r_arready;
    assign RVALID   = r_rvalid;
    assign RLAST    = r_rlast;
    assign RID      = r_rid;
    assign RDATA    = r_rdata;
    assign RRESP    = r_rresp;
    assign mem_cs   = (r_state == S_FETCH) & ~r_err;
    assign mem_addr = r_addr;

endmodule

// File: tb/tb_sram_read_slave.sv
// Bench for sram_read_slave: directed and random bursts against a behavioural
// burst model, with an SRAM model that returns garbage whenever not strobed.
module tb_sram_read_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ARID = '0;
    logic [31:0] ARADDR = '0;
    logic [3:0]  ARLEN = '0;
    logic [2:0]  ARSIZE = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        mem_cs;
    logic [13:0] mem_addr;
    logic [31:0] mem_rdata = '0;

    sram_read_slave #(.IDS_W(8), .DATA_W(32), .ADDR_W(32), .MEM_AW(14)) dut (
        .clk(clk), .rst(rst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:16383];
    logic        cs_s = 1'b0;
    logic [13:0] addr_s = '0;
    logic [13:0] strobes [$];

    always @(negedge clk) begin
        cs_s   = mem_cs;
        addr_s = mem_addr;
        if (rst && mem_cs) strobes.push_back(mem_addr);
    end

    // Data is only meaningful in the cycle after a strobe; otherwise noise.
    always @(posedge clk) mem_rdata <= cs_s ? mem[addr_s] : $urandom;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int stall_beat,
                           input int stall_len, input int max_stall,
                           input int abort_beat);
        logic        err;
        logic [13:0] w0;
        logic [13:0] wa;
        logic [43:0] exp_r;
        logic [13:0] exp_addr [$];
        int          lat;
        int          stall;

        err = (size != 3'b010) || burst[1];
        w0  = addr[15:2];
        strobes.delete();

        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        lat = 0;
        while (!ARREADY && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!ARREADY) chk("ar_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        ARVALID = 1'b0;
        chk("cs_after_ar", {63'd0, mem_cs}, {63'd0, !err});
        chk("arready_busy", {63'd0, ARREADY}, 64'd0);

        for (int b = 0; b <= int'(len); b++) begin
            wa = (burst == 2'b01) ? w0 + 14'(b) : w0;
            if (!err) exp_addr.push_back(wa);
            exp_r = {id, err ? 32'd0 : mem[wa], err ? 2'b10 : 2'b00,
                     b == int'(len), 1'b1};

            lat = 0;
            while (!RVALID && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("rvalid_latency", 64'(lat), 64'd2);

            if (b == abort_beat) begin
                rst = 1'b0;
                #1;
                chk("reset_async",
                    {4'd0, ARREADY, RVALID, RLAST, RID, RDATA, RRESP, mem_cs, mem_addr},
                    64'd0);
                @(negedge clk);
                rst = 1'b1;
                #1;
                chk("arready_at_release", {63'd0, ARREADY}, 64'd0);
                @(negedge clk);
                chk("arready_after_release", {63'd0, ARREADY}, 64'd1);
                chk("rvalid_after_release", {63'd0, RVALID}, 64'd0);
                return;
            end

            stall = (b == stall_beat) ? stall_len : $urandom_range(0, max_stall);
            for (int s = 0; s < stall; s++) begin
                chk("r_hold", {20'd0, RID, RDATA, RRESP, RLAST, RVALID}, {20'd0, exp_r});
                @(negedge clk);
            end
            chk("r_beat", {20'd0, RID, RDATA, RRESP, RLAST, RVALID}, {20'd0, exp_r});
            RREADY = 1'b1;
            @(negedge clk);
            RREADY = 1'b0;
            chk("rvalid_clear", {63'd0, RVALID}, 64'd0);
        end

        chk("arready_back", {63'd0, ARREADY}, 64'd1);
        chk("strobe_count", 64'(strobes.size()), 64'(exp_addr.size()));
        for (int i = 0; i < strobes.size() && i < exp_addr.size(); i++)
            chk("strobe_addr", {50'd0, strobes[i]}, {50'd0, exp_addr[i]});
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[14'h0010] = 32'hDEADBEEF;
        mem[14'h0040] = 32'd1;
        mem[14'h0041] = 32'd2;
        mem[14'h0042] = 32'd3;
        mem[14'h0043] = 32'd4;
        mem[14'h3FFF] = 32'hA5A5_0001;
        mem[14'h0000] = 32'h5A5A_0002;

        @(negedge clk);
        @(negedge clk);
        chk("reset_values",
            {4'd0, ARREADY, RVALID, RLAST, RID, RDATA, RRESP, mem_cs, mem_addr}, 64'd0);
        rst = 1'b1;
        #1;
        chk("arready_first_release", {63'd0, ARREADY}, 64'd0);
        @(negedge clk);
        chk("arready_first_edge", {63'd0, ARREADY}, 64'd1);

        do_read(8'h13, 32'h0000_0040, 4'd0, 3'b010, 2'b01, -1, 0, 0, -1);
        do_read(8'h21, 32'h0000_0100, 4'd3, 3'b010, 2'b01, -1, 0, 0, -1);
        do_read(8'h22, 32'h0000_0100, 4'd3, 3'b010, 2'b01, 1, 5, 0, -1);
        do_read(8'h35, 32'h0000_0200, 4'd2, 3'b010, 2'b00, -1, 0, 2, -1);
        do_read(8'h47, 32'h1234_FFFC, 4'd1, 3'b010, 2'b01, -1, 0, 0, -1);
        do_read(8'h5C, 32'h0000_0300, 4'd1, 3'b001, 2'b01, -1, 0, 1, -1);
        do_read(8'h6E, 32'h0000_0400, 4'd1, 3'b010, 2'b10, -1, 0, 1, -1);
        do_read(8'h71, 32'h0000_FFC0, 4'd15, 3'b010, 2'b01, -1, 0, 0, -1);
        do_read(8'h88, 32'h0000_0100, 4'd3, 3'b010, 2'b01, -1, 0, 0, 1);
        do_read(8'h13, 32'h0000_0040, 4'd0, 3'b010, 2'b01, -1, 0, 0, -1);

        for (int t = 0; t < 40; t++) begin
            logic [2:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b010;
            do_read(8'($urandom), $urandom, 4'($urandom), sz,
                    2'($urandom), -1, 0, 3, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
